color_bar_sequencer: RTL and testbench

//  Frame/line timing controller for the colour-column pattern generator.

---
 rtl/color_bar_pkg.sv | 29 ++
 rtl/color_bar_sequencer_gap.sv | 29 ++
 rtl/color_bar_sequencer.sv | 174 +++++++++++++++++
 tb/tb_color_bar_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_bar_pkg.sv
// color_bar_pkg: shared types for the colour-bar sequencer and the colour-column generator.
package color_bar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FS,
    ACTIVE,
    LGAP,
    FE,
    FGAP
  } seq_state_e;

  typedef enum logic [2:0] {
    WHITE,
    YELLOW,
    CYAN,
    GREEN,
    MAGENTA,
    RED,
    BLUE,
    BLACK
  } color_e;

  // Pixels per line from the byte budget of one line at the given bit depth.
  function automatic int n_pixels(input int bytes_per_line, input int bpp);
    return (bytes_per_line * 8) / bpp;
  endfunction

endpackage

// File: rtl/color_bar_sequencer_gap.sv
// seq_gap_counter: loadable down-counter; done is high on the last cycle of the loaded gap.
module seq_gap_counter
  import color_bar_pkg::*;
#(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             done
);

  logic [GAP_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - GAP_W'(1);
    end
  end

  // A load of N yields exactly N cycles with count in N..1; done marks the last.
  assign done = (count == GAP_W'(1));

endmodule

// File: rtl/color_bar_sequencer.sv
// color_bar_sequencer: frame/line timing for the colour-column generator with FS/FE framing.
// Per-frame bar scrolling is built only when COLOR_BAR_SEQ_SCROLL_EN is defined.
module color_bar_sequencer
  import color_bar_pkg::*;
#(
  parameter int PIXELS_8BIT_PER_LINE = 3240,
  parameter int BPP                  = 10,
  parameter int WIDTH_N_PIXELS       = 13,
  parameter int N_LINES              = 1944,
  parameter int WIDTH_N_LINES        = 13,
  parameter int LINE_GAP             = 16,
  parameter int FRAME_GAP            = 64,
  parameter int OFFSET_STEP          = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      ready,
  output logic                      fs_strb,
  output logic                      fe_strb,
  output logic                      pix_valid,
  output logic                      line_first,
  output logic                      line_last,
  output logic [WIDTH_N_PIXELS-1:0] pixel_index,
  output logic [WIDTH_N_PIXELS-1:0] cols_offset,
  output logic [WIDTH_N_LINES-1:0]  line_index,
  output logic                      busy
);

  localparam int N_PIXELS = n_pixels(PIXELS_8BIT_PER_LINE, BPP);
  localparam int GAP_MAX  = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GAP_W    = $clog2(GAP_MAX) + 1;

  localparam logic [WIDTH_N_PIXELS-1:0] LAST_PIX  = WIDTH_N_PIXELS'(N_PIXELS - 1);
  localparam logic [WIDTH_N_PIXELS-1:0] PIX_ONE   = WIDTH_N_PIXELS'(1);
  localparam logic [WIDTH_N_LINES-1:0]  LAST_LINE = WIDTH_N_LINES'(N_LINES - 1);
  localparam logic [WIDTH_N_LINES-1:0]  LINE_ONE  = WIDTH_N_LINES'(1);

  if (LINE_GAP < 1 || FRAME_GAP < 1 || OFFSET_STEP < 0 ||
      N_PIXELS < 1 || N_PIXELS > (2 ** WIDTH_N_PIXELS) ||
      N_LINES < 1 || N_LINES > (2 ** WIDTH_N_LINES)) begin : g_bad_params
    $error("color_bar_sequencer: parameter set out of range");
  end

  seq_state_e                state;
  logic                      gap_load;
  logic                      gap_done;
  logic [GAP_W-1:0]          gap_val;
  logic [WIDTH_N_PIXELS-1:0] next_offset;

`ifdef COLOR_BAR_SEQ_SCROLL_EN
  localparam int OW = WIDTH_N_PIXELS + 1;

  // Modulo-N_PIXELS advance; one extra bit keeps the sum from wrapping early.
  function automatic logic [WIDTH_N_PIXELS-1:0] wrap_offset(input logic [WIDTH_N_PIXELS-1:0] off);
    logic [OW-1:0] sum;
    sum = {1'b0, off} + OW'(OFFSET_STEP);
    if (sum >= OW'(N_PIXELS)) begin
      sum = sum - OW'(N_PIXELS);
    end
    return sum[WIDTH_N_PIXELS-1:0];
  endfunction

  assign next_offset = wrap_offset(cols_offset);
`else
  assign next_offset = '0;
`endif

  // The gap counter is armed on the transfer that leaves ACTIVE for LGAP or FE for FGAP.
  assign gap_load = ready && (((state == ACTIVE) && (pixel_index == LAST_PIX) &&
                               (line_index != LAST_LINE)) || (state == FE));
  assign gap_val  = (state == FE) ? GAP_W'(FRAME_GAP) : GAP_W'(LINE_GAP);

  seq_gap_counter #(
    .GAP_W(GAP_W)
  ) u_gap (
    .clk     (clk),
    .rst     (rst),
    .load    (gap_load),
    .load_val(gap_val),
    .done    (gap_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fs_strb     <= 1'b0;
      fe_strb     <= 1'b0;
      pix_valid   <= 1'b0;
      line_first  <= 1'b0;
      line_last   <= 1'b0;
      pixel_index <= '0;
      cols_offset <= '0;
      line_index  <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state   <= FS;
            fs_strb <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FS: begin
          if (ready) begin
            state       <= ACTIVE;
            fs_strb     <= 1'b0;
            pix_valid   <= 1'b1;
            line_first  <= 1'b1;
            line_last   <= (LAST_PIX == '0);
            pixel_index <= '0;
            line_index  <= '0;
          end
        end
        ACTIVE: begin
          if (ready) begin
            if (pixel_index == LAST_PIX) begin
              pix_valid  <= 1'b0;
              line_first <= 1'b0;
              line_last  <= 1'b0;
              if (line_index == LAST_LINE) begin
                state   <= FE;
                fe_strb <= 1'b1;
              end else begin
                state <= LGAP;
              end
            end else begin
              pixel_index <= pixel_index + PIX_ONE;
              line_first  <= 1'b0;
              line_last   <= ((pixel_index + PIX_ONE) == LAST_PIX);
            end
          end
        end
        LGAP: begin
          if (gap_done) begin
            state       <= ACTIVE;
            pix_valid   <= 1'b1;
            line_first  <= 1'b1;
            line_last   <= (LAST_PIX == '0);
            pixel_index <= '0;
            line_index  <= line_index + LINE_ONE;
          end
        end
        FE: begin
          if (ready) begin
            state       <= FGAP;
            fe_strb     <= 1'b0;
            cols_offset <= next_offset;
          end
        end
        FGAP: begin
          if (gap_done) begin
            if (enable) begin
              state   <= FS;
              fs_strb <= 1'b1;
            end else begin
              // Idle presents an all-zero output bundle, scroll position included.
              state       <= IDLE;
              busy        <= 1'b0;
              pixel_index <= '0;
              line_index  <= '0;
              cols_offset <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_bar_sequencer.sv
// tb_color_bar_sequencer: scoreboard bench for color_bar_sequencer (8 pixels x 3 lines, gaps 2/4).
module tb_color_bar_sequencer;

  localparam int NPIX   = 8;
  localparam int NLIN   = 3;
  localparam int LGAP_C = 2;
  localparam int FGAP_C = 4;
  localparam int STEP   = 3;
  localparam int PW     = 13;
  localparam int LW     = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          ready = 1'b0;
  logic          fs_strb, fe_strb, pix_valid, line_first, line_last, busy;
  logic [PW-1:0] pixel_index, cols_offset;
  logic [LW-1:0] line_index;

  color_bar_sequencer #(
    .PIXELS_8BIT_PER_LINE(10),
    .BPP                 (10),
    .WIDTH_N_PIXELS      (PW),
    .N_LINES             (NLIN),
    .WIDTH_N_LINES       (LW),
    .LINE_GAP            (LGAP_C),
    .FRAME_GAP           (FGAP_C),
    .OFFSET_STEP         (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ready      (ready),
    .fs_strb    (fs_strb),
    .fe_strb    (fe_strb),
    .pix_valid  (pix_valid),
    .line_first (line_first),
    .line_last  (line_last),
    .pixel_index(pixel_index),
    .cols_offset(cols_offset),
    .line_index (line_index),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb[$];
  int          fs_cnt = 0;
  int          offs[4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] enc(input int kind, input logic first, input logic last,
                                      input int line, input int pix, input int off);
    return 64'({2'(kind), first, last, 13'(line), 13'(pix), 13'(off)});
  endfunction

  function automatic logic [63:0] snap();
    return 64'({fs_strb, fe_strb, pix_valid, line_first, line_last, busy,
                pixel_index, cols_offset, line_index});
  endfunction

  task automatic push_frame(input int off);
    sb.push_back(enc(0, 1'b0, 1'b0, 0, 0, 0));
    for (int l = 0; l < NLIN; l++) begin
      for (int p = 0; p < NPIX; p++) begin
        sb.push_back(enc(2, p == 0, p == NPIX - 1, l, p, off));
      end
    end
    sb.push_back(enc(1, 1'b0, 1'b0, 0, 0, 0));
  endtask

  // Monitor: beats against the scoreboard, gap lengths, stall freeze, exclusivity.
  logic        prev_act = 1'b0;
  logic        prev_stall = 1'b0;
  logic        after_fe = 1'b0;
  logic [63:0] prev_snap = '0;
  int          idle = 0;

  always @(negedge clk) begin : mon
    logic        act;
    logic [63:0] got;
    logic [63:0] exp;
    if (rst) begin
      prev_act   = 1'b0;
      prev_stall = 1'b0;
      after_fe   = 1'b0;
      idle       = 0;
    end else begin
      act = fs_strb | fe_strb | pix_valid;
      check_eq("exclusive", 64'($countones({fs_strb, fe_strb, pix_valid}) > 1), 64'd0);
      if (prev_stall) check_eq("hold", snap(), prev_snap);
      if (act && !prev_act) begin
        if (pix_valid && line_first && line_index != '0)
          check_eq("lgap_len", 64'(idle), 64'(LGAP_C));
        if (fs_strb && after_fe)
          check_eq("fgap_len", 64'(idle), 64'(FGAP_C));
      end
      if (!act && !busy) after_fe = 1'b0;
      if (act && ready) begin
        if (fs_strb)      got = enc(0, 1'b0, 1'b0, 0, 0, 0);
        else if (fe_strb) got = enc(1, 1'b0, 1'b0, 0, 0, 0);
        else              got = enc(2, line_first, line_last, int'(line_index),
                                    int'(pixel_index), int'(cols_offset));
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          exp = sb.pop_front();
          check_eq("beat", got, exp);
        end
        if (fs_strb) begin
          fs_cnt++;
          after_fe = 1'b0;
        end
        if (fe_strb) after_fe = 1'b1;
      end
      idle       = act ? 0 : idle + 1;
      prev_act   = act;
      prev_stall = act && !ready;
      prev_snap  = snap();
    end
  end

  // md 0: always ready; 1: directed stalls (FS, line 1 pixel 3, FE, gaps); 2: random.
  task automatic run(input int nfr, input int md);
    int st_fs = 0;
    int st_px = 0;
    int st_fe = 0;
    int cyc = 0;
    int base;
    bit started = 1'b0;
    bit fin = 1'b0;
    base = fs_cnt;
    for (int f = 0; f < nfr; f++) push_frame(offs[f]);
    enable = 1'b1;
    ready  = 1'b1;
    while (!fin && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) started = 1'b1;
      if (fs_cnt - base >= nfr) enable = 1'b0;
      case (md)
        1: begin
          if (fs_strb && st_fs < 3) begin
            ready = 1'b0;
            st_fs++;
          end else if (pix_valid && line_index == 13'd1 && pixel_index == 13'd3 && st_px < 5) begin
            ready = 1'b0;
            st_px++;
          end else if (fe_strb && st_fe < 3) begin
            ready = 1'b0;
            st_fe++;
          end else begin
            ready = fs_strb | fe_strb | pix_valid;
          end
        end
        2:       ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
      if (started && !busy) fin = 1'b1;
    end
    enable = 1'b0;
    check_eq("run_done", 64'(fin), 64'd1);
    check_eq("sb_left", 64'(sb.size()), 64'd0);
    check_eq("idle_outs", snap(), 64'd0);
  endtask

  // Reset lands while frame 2 shows line 2 pixel 5; no FE may follow.
  task automatic reset_mid_frame();
    int cyc = 0;
    int base;
    bit hit = 1'b0;
    base = fs_cnt;
    push_frame(offs[0]);
    push_frame(offs[1]);
    enable = 1'b1;
    ready  = 1'b1;
    while (!hit && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (fs_cnt - base == 2 && pix_valid && line_index == 13'd2 && pixel_index == 13'd5)
        hit = 1'b1;
    end
    check_eq("rst_reach", 64'(hit), 64'd1);
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check_eq("rst_outs", snap(), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("rst_quiet", snap(), 64'd0);
  endtask

  initial begin
`ifdef COLOR_BAR_SEQ_SCROLL_EN
    offs[0] = 0; offs[1] = 3; offs[2] = 6; offs[3] = 1;
`else
    offs[0] = 0; offs[1] = 0; offs[2] = 0; offs[3] = 0;
`endif
    rst    = 1'b1;
    enable = 1'b1;
    ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", snap(), 64'd0);
    enable = 1'b0;
    rst    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_no_enable", snap(), 64'd0);

    run(4, 0);
    run(1, 1);
    run(2, 2);
    reset_mid_frame();
    run(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
